// File: rtl/ddr_port_arbiter_2to1_if.sv
// Avalon-MM burst link used for both masters and the shared DDR port.
interface ddr_port_arbiter_2to1_if #(
    parameter int AWIDTH  = 28,
    parameter int DWIDTH  = 256,
    parameter int BEWIDTH = 32,
    parameter int BCWIDTH = 5
);
    logic [AWIDTH-1:0]  address;
    logic               read;
    logic               write;
    logic [DWIDTH-1:0]  writedata;
    logic [BEWIDTH-1:0] byteenable;
    logic [BCWIDTH-1:0] burstcount;
    logic               waitrequest;
    logic [DWIDTH-1:0]  readdata;
    logic               readdatavalid;
    logic               writeack;

    modport master (
        output address, read, write, writedata, byteenable, burstcount,
        input  waitrequest, readdata, readdatavalid, writeack
    );

    modport slave (
        input  address, read, write, writedata, byteenable, burstcount,
        output waitrequest, readdata, readdatavalid, writeack
    );
endinterface

// File: rtl/ddr_port_arbiter_2to1.sv
// Two Avalon-MM masters share one DDR port: round-robin grant, write bursts
// hold the grant until their last beat, responses routed by issue-order tag FIFOs.

// Small tag FIFO; a push becomes visible at the head on the following cycle.
module ddr_port_arbiter_2to1_tagfifo #(
    parameter int W     = 1,
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;

    // Pointers and occupancy; callers never push when full or pop when empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + AW'(1);
            if (pop_i)  rptr_q <= rptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

module ddr_port_arbiter_2to1 #(
    parameter int AWIDTH   = 28,
    parameter int DWIDTH   = 256,
    parameter int BEWIDTH  = 32,
    parameter int BCWIDTH  = 5,
    parameter int RD_DEPTH = 16,
    parameter int WR_DEPTH = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    ddr_port_arbiter_2to1_if.slave         m0,
    ddr_port_arbiter_2to1_if.slave         m1,
    ddr_port_arbiter_2to1_if.master        avm,
    output logic                           error
);
    localparam int RD_W = 1 + BCWIDTH;

    // Arbitration state
    logic               rr_q, rr_d;
    logic               lock_q, lock_d;
    logic               lock_id_q, lock_id_d;
    logic [BCWIDTH-1:0] wbeats_q, wbeats_d;
    logic [BCWIDTH-1:0] rbeats_q, rbeats_d;
    logic               error_q, error_d;

    // Selected master view
    logic [1:0]         req;
    logic               sel;
    logic [AWIDTH-1:0]  s_addr;
    logic               s_read, s_write;
    logic [DWIDTH-1:0]  s_wdata;
    logic [BEWIDTH-1:0] s_be;
    logic [BCWIDTH-1:0] s_bc, s_bc_eff;
    logic               stall, lock_rd_viol, s_wait;
    logic               go_read, go_write, rd_acc, wr_acc;

    // Tag FIFO plumbing
    logic [RD_W-1:0]    rd_dout;
    logic               rd_full, rd_empty, rd_push, rd_pop;
    logic               wr_dout, wr_full, wr_empty, wr_push, wr_pop;
    logic               rd_head_id;
    logic [BCWIDTH-1:0] rd_head_bc;
    logic               rdv_ok, rbeat_last, wack_ok;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    // Grant: a locked write burst keeps the port; otherwise rr_ptr has priority.
    always_comb begin
        sel = rr_q;
        if (lock_q)
            sel = lock_id_q;
        else if (req[rr_q])
            sel = rr_q;
        else if (req[~rr_q])
            sel = ~rr_q;
    end

    assign s_addr   = sel ? m1.address    : m0.address;
    assign s_read   = sel ? m1.read       : m0.read;
    assign s_write  = sel ? m1.write      : m0.write;
    assign s_wdata  = sel ? m1.writedata  : m0.writedata;
    assign s_be     = sel ? m1.byteenable : m0.byteenable;
    assign s_bc     = sel ? m1.burstcount : m0.burstcount;
    // A zero burstcount is flagged and then handled as a single beat.
    assign s_bc_eff = (s_bc == '0) ? BCWIDTH'(1) : s_bc;

    // Only the first write beat allocates a write-ack tag.
    assign stall        = (s_read & rd_full) | (s_write & ~lock_q & wr_full);
    assign lock_rd_viol = lock_q & s_read;
    assign go_read      = ~reset & s_read & ~lock_q & ~stall;
    assign go_write     = ~reset & s_write & ~stall;
    assign rd_acc       = go_read & ~avm.waitrequest;
    assign wr_acc       = go_write & ~avm.waitrequest;
    assign s_wait       = reset | avm.waitrequest | stall | lock_rd_viol;

    assign avm.address    = s_addr;
    assign avm.read       = go_read;
    assign avm.write      = go_write;
    assign avm.writedata  = s_wdata;
    assign avm.byteenable = s_be;
    assign avm.burstcount = s_bc_eff;

    assign m0.waitrequest = sel ? 1'b1 : s_wait;
    assign m1.waitrequest = sel ? s_wait : 1'b1;
    assign m0.readdata    = avm.readdata;
    assign m1.readdata    = avm.readdata;

    // Response routing from the head of each tag FIFO.
    assign rd_head_id = rd_dout[RD_W-1];
    assign rd_head_bc = rd_dout[BCWIDTH-1:0];
    assign rdv_ok     = ~reset & avm.readdatavalid & ~rd_empty;
    assign rbeat_last = ((rbeats_q + BCWIDTH'(1)) == rd_head_bc);
    assign rd_push    = rd_acc;
    assign rd_pop     = rdv_ok & rbeat_last;
    assign wack_ok    = ~reset & avm.writeack & ~wr_empty;
    assign wr_push    = wr_acc & ~lock_q;
    assign wr_pop     = wack_ok;

    assign m0.readdatavalid = rdv_ok & ~rd_head_id;
    assign m1.readdatavalid = rdv_ok &  rd_head_id;
    assign m0.writeack      = wack_ok & ~wr_dout;
    assign m1.writeack      = wack_ok &  wr_dout;

    ddr_port_arbiter_2to1_tagfifo #(.W(RD_W), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (rd_push),
        .din_i   ({sel, s_bc_eff}),
        .pop_i   (rd_pop),
        .dout_o  (rd_dout),
        .full_o  (rd_full),
        .empty_o (rd_empty)
    );

    ddr_port_arbiter_2to1_tagfifo #(.W(1), .DEPTH(WR_DEPTH)) u_wr_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (wr_push),
        .din_i   (sel),
        .pop_i   (wr_pop),
        .dout_o  (wr_dout),
        .full_o  (wr_full),
        .empty_o (wr_empty)
    );

    // Next state: rr pointer, burst lock, read beat counter, sticky error.
    always_comb begin
        rr_d      = rr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        wbeats_d  = wbeats_q;
        rbeats_d  = rbeats_q;
        error_d   = error_q;

        if (rd_acc)
            rr_d = ~sel;

        if (wr_acc) begin
            if (!lock_q) begin
                if (s_bc_eff == BCWIDTH'(1)) begin
                    rr_d = ~sel;
                end else begin
                    lock_d    = 1'b1;
                    lock_id_d = sel;
                    wbeats_d  = s_bc_eff - BCWIDTH'(1);
                end
            end else begin
                wbeats_d = wbeats_q - BCWIDTH'(1);
                if (wbeats_q == BCWIDTH'(1)) begin
                    lock_d = 1'b0;
                    rr_d   = ~lock_id_q;
                end
            end
        end

        if (rdv_ok)
            rbeats_d = rbeat_last ? '0 : rbeats_q + BCWIDTH'(1);

        if ((avm.readdatavalid & rd_empty) |
            (avm.writeack & wr_empty) |
            ((rd_acc | (wr_acc & ~lock_q)) & (s_bc == '0)) |
            lock_rd_viol)
            error_d = 1'b1;
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q      <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            wbeats_q  <= '0;
            rbeats_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            wbeats_q  <= wbeats_d;
            rbeats_q  <= rbeats_d;
            error_q   <= error_d;
        end
    end

    assign error = error_q;
endmodule

// File: tb/tb_ddr_port_arbiter_2to1.sv
// Randomized bench for ddr_port_arbiter_2to1 against a queue-based reference model.
module tb_ddr_port_arbiter_2to1;
    localparam int AW = 28, DW = 256, BEW = 32, BCW = 5, RDD = 16, WRD = 16;

    logic clock = 1'b0;
    logic reset;
    logic error;

    always #5 clock = ~clock;

    ddr_port_arbiter_2to1_if #(.AWIDTH(AW), .DWIDTH(DW), .BEWIDTH(BEW), .BCWIDTH(BCW)) m0_if ();
    ddr_port_arbiter_2to1_if #(.AWIDTH(AW), .DWIDTH(DW), .BEWIDTH(BEW), .BCWIDTH(BCW)) m1_if ();
    ddr_port_arbiter_2to1_if #(.AWIDTH(AW), .DWIDTH(DW), .BEWIDTH(BEW), .BCWIDTH(BCW)) avm_if ();

    ddr_port_arbiter_2to1 #(
        .AWIDTH(AW), .DWIDTH(DW), .BEWIDTH(BEW), .BCWIDTH(BCW), .RD_DEPTH(RDD), .WR_DEPTH(WRD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .avm   (avm_if),
        .error (error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Master agents
    bit          a_act[2], a_wr[2], a_viol[2];
    logic [AW-1:0] a_addr[2];
    int          a_bc[2], a_left[2];
    // Knobs
    int p_wait = 0, p_rdv = 0, p_wack = 0, p_new = 0;
    bit force_rdv = 0, force_wack = 0, auto_rd = 0;
    // DDR responder debt
    int owed_rd = 0, owed_wk = 0;
    // Reference model
    typedef struct { int id; int bc; } rd_t;
    rd_t rdq[$];
    int  wrq[$];
    int  owner = -1, turn = 0, rbeat = 0, wleft = 0;
    bit  merr = 0;
    // Observation logs
    int  rdv_log[$], gnt_log[$], w0_log[$];
    bit  last_err, last_avm_read, last_avm_write, last_w0;

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic issue(input int id, input bit wr, input int bc);
        a_act[id]  = 1;
        a_wr[id]   = wr;
        a_addr[id] = AW'($urandom);
        a_bc[id]   = bc;
        a_left[id] = (bc == 0) ? 1 : bc;
    endtask

    task automatic drive_inputs();
        m0_if.read       = (a_act[0] && !a_wr[0]) || a_viol[0];
        m0_if.write      = a_act[0] && a_wr[0] && !a_viol[0];
        m0_if.address    = a_addr[0];
        m0_if.burstcount = BCW'(a_bc[0]);
        m0_if.writedata  = rnd256();
        m0_if.byteenable = BEW'($urandom);
        m1_if.read       = (a_act[1] && !a_wr[1]) || a_viol[1];
        m1_if.write      = a_act[1] && a_wr[1] && !a_viol[1];
        m1_if.address    = a_addr[1];
        m1_if.burstcount = BCW'(a_bc[1]);
        m1_if.writedata  = rnd256();
        m1_if.byteenable = BEW'($urandom);
        avm_if.waitrequest   = ($urandom_range(99) < p_wait);
        avm_if.readdatavalid = force_rdv || (owed_rd > 0 && $urandom_range(99) < p_rdv);
        avm_if.writeack      = force_wack || (owed_wk > 0 && $urandom_range(99) < p_wack);
        avm_if.readdata      = rnd256();
    endtask

    task automatic new_cmds();
        for (int i = 0; i < 2; i++) begin
            if (!a_act[i]) begin
                if (auto_rd) issue(i, 0, 1);
                else if (p_new > 0 && $urandom_range(99) < p_new)
                    issue(i, $urandom_range(1), $urandom_range(6, 1));
            end
        end
    endtask

    // Compare one cycle of DUT behaviour with the model, then advance the model.
    task automatic check_cycle();
        bit rd[2], wr[2], req[2], wq[2], e_rdv[2], e_wk[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] wd[2];
        logic [BEW-1:0] be[2];
        int bc[2];
        int sel, bce, gnt;
        bit stall, viol, e_rd, e_wr, aw, acc, nerr;

        rd[0] = m0_if.read;  wr[0] = m0_if.write;  ad[0] = m0_if.address;
        rd[1] = m1_if.read;  wr[1] = m1_if.write;  ad[1] = m1_if.address;
        wd[0] = m0_if.writedata; be[0] = m0_if.byteenable; bc[0] = int'(m0_if.burstcount);
        wd[1] = m1_if.writedata; be[1] = m1_if.byteenable; bc[1] = int'(m1_if.burstcount);
        wq[0] = m0_if.waitrequest; wq[1] = m1_if.waitrequest;
        aw = avm_if.waitrequest;

        last_err = error; last_avm_read = avm_if.read; last_avm_write = avm_if.write;
        last_w0 = m0_if.waitrequest;
        gnt = !wq[0] ? 0 : (!wq[1] ? 1 : -1);
        gnt_log.push_back(gnt);
        w0_log.push_back(int'(wq[0]));

        if (reset) begin
            chk("rst_avm_read", 256'(avm_if.read), 256'(0));
            chk("rst_avm_write", 256'(avm_if.write), 256'(0));
            chk("rst_wait0", 256'(wq[0]), 256'(1));
            chk("rst_wait1", 256'(wq[1]), 256'(1));
            chk("rst_rdv", 256'({m1_if.readdatavalid, m0_if.readdatavalid}), 256'(0));
            chk("rst_wack", 256'({m1_if.writeack, m0_if.writeack}), 256'(0));
            rdq.delete(); wrq.delete();
            owner = -1; turn = 0; rbeat = 0; wleft = 0; merr = 0;
            owed_rd = 0; owed_wk = 0;
            for (int i = 0; i < 2; i++) begin a_act[i] = 0; a_viol[i] = 0; end
            return;
        end

        chk("error", 256'(error), 256'(merr));
        nerr = 0;
        req[0] = rd[0] | wr[0];
        req[1] = rd[1] | wr[1];
        if (owner >= 0)        sel = owner;
        else if (req[turn])    sel = turn;
        else if (req[1-turn])  sel = 1 - turn;
        else                   sel = turn;
        bce   = (bc[sel] == 0) ? 1 : bc[sel];
        stall = (rd[sel] && rdq.size() == RDD) || (wr[sel] && owner < 0 && wrq.size() == WRD);
        viol  = (owner >= 0) && rd[sel];
        e_rd  = rd[sel] && owner < 0 && !stall;
        e_wr  = wr[sel] && !stall;

        chk("avm_read", 256'(avm_if.read), 256'(e_rd));
        chk("avm_write", 256'(avm_if.write), 256'(e_wr));
        if (e_rd || e_wr) begin
            chk("avm_addr", 256'(avm_if.address), 256'(ad[sel]));
            chk("avm_bc", 256'(avm_if.burstcount), 256'(bce));
        end
        if (e_wr) begin
            chk("avm_wdata", avm_if.writedata, wd[sel]);
            chk("avm_be", 256'(avm_if.byteenable), 256'(be[sel]));
        end
        for (int i = 0; i < 2; i++)
            if (req[i])
                chk(i == 0 ? "wait0" : "wait1", 256'(wq[i]),
                    256'((i == sel) ? (aw | stall | viol) : 1'b1));

        // Read return routing
        e_rdv[0] = 0; e_rdv[1] = 0;
        if (avm_if.readdatavalid) begin
            if (owed_rd > 0) owed_rd--;
            if (rdq.size() == 0) nerr = 1;
            else begin
                e_rdv[rdq[0].id] = 1;
                rdv_log.push_back(rdq[0].id);
                rbeat++;
                if (rbeat == rdq[0].bc) begin void'(rdq.pop_front()); rbeat = 0; end
            end
        end
        chk("rdv0", 256'(m0_if.readdatavalid), 256'(e_rdv[0]));
        chk("rdv1", 256'(m1_if.readdatavalid), 256'(e_rdv[1]));
        if (e_rdv[0]) chk("rdata0", m0_if.readdata, avm_if.readdata);
        if (e_rdv[1]) chk("rdata1", m1_if.readdata, avm_if.readdata);

        // Write ack routing
        e_wk[0] = 0; e_wk[1] = 0;
        if (avm_if.writeack) begin
            if (owed_wk > 0) owed_wk--;
            if (wrq.size() == 0) nerr = 1;
            else e_wk[wrq.pop_front()] = 1;
        end
        chk("wack0", 256'(m0_if.writeack), 256'(e_wk[0]));
        chk("wack1", 256'(m1_if.writeack), 256'(e_wk[1]));

        // Acceptance
        acc = (e_rd || e_wr) && !aw;
        if (acc && e_rd) begin
            rd_t t;
            t.id = sel; t.bc = bce;
            rdq.push_back(t);
            owed_rd += bce;
            turn = 1 - sel;
            if (bc[sel] == 0) nerr = 1;
            a_act[sel] = 0;
        end
        if (acc && e_wr) begin
            if (owner < 0) begin
                wrq.push_back(sel);
                owed_wk++;
                if (bc[sel] == 0) nerr = 1;
                if (bce == 1) turn = 1 - sel;
                else begin owner = sel; wleft = bce - 1; end
            end else begin
                wleft--;
                if (wleft == 0) begin owner = -1; turn = 1 - sel; end
            end
            a_left[sel]--;
            if (a_left[sel] == 0) a_act[sel] = 0;
        end
        if (viol) nerr = 1;
        if (nerr) merr = 1;
        a_viol[0] = 0; a_viol[1] = 0;
    endtask

    task automatic step();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        #1;
        new_cmds();
        drive_inputs();
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((a_act[0] || a_act[1] || rdq.size() != 0 || wrq.size() != 0) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) chk("idle_timeout", 256'(1), 256'(0));
    endtask

    task automatic do_reset();
        reset = 1;
        drive_inputs();
        step();
        step();
        reset = 0;
        drive_inputs();
        step();
    endtask

    initial begin
        int exp_rdv[6] = '{0, 0, 0, 0, 1, 1};
        int turn0;

        reset = 1;
        for (int i = 0; i < 2; i++) begin a_act[i] = 0; a_viol[i] = 0; a_bc[i] = 1; end
        @(posedge clock);
        #1;
        drive_inputs();
        do_reset();
        chk("rst_error_clear", 256'(last_err), 256'(0));

        // Two read bursts return in issue order
        p_rdv = 100;
        rdv_log.delete();
        issue(0, 0, 4);
        issue(1, 0, 2);
        drive_inputs();
        wait_idle(60);
        chk("rdv_count", 256'(rdv_log.size()), 256'(6));
        for (int i = 0; i < 6 && i < rdv_log.size(); i++)
            chk("rdv_order", 256'(rdv_log[i]), 256'(exp_rdv[i]));

        // Continuous reads from both masters alternate
        turn0 = turn;
        auto_rd = 1;
        issue(0, 0, 1);
        issue(1, 0, 1);
        drive_inputs();
        gnt_log.delete();
        repeat (8) step();
        auto_rd = 0;
        for (int i = 0; i < 8; i++)
            chk("rr_alternate", 256'(gnt_log[i]), 256'((turn0 + i) % 2));
        wait_idle(60);

        // Locked write burst holds off the other master
        p_wack = 100;
        issue(1, 1, 3);
        drive_inputs();
        step();
        issue(0, 0, 1);
        drive_inputs();
        w0_log.delete();
        repeat (3) step();
        chk("lock_wait_b2", 256'(w0_log[0]), 256'(1));
        chk("lock_wait_b3", 256'(w0_log[1]), 256'(1));
        chk("lock_grant", 256'(w0_log[2]), 256'(0));
        wait_idle(60);

        // 16 reads outstanding stall the 17th
        p_rdv = 0;
        for (int i = 0; i < RDD; i++) begin
            issue(0, 0, 1);
            drive_inputs();
            step();
        end
        issue(0, 0, 1);
        drive_inputs();
        step();
        chk("full_avm_read", 256'(last_avm_read), 256'(0));
        chk("full_wait0", 256'(last_w0), 256'(1));
        p_rdv = 100;
        wait_idle(80);
        chk("full_drained_err", 256'(last_err), 256'(0));

        // Spurious readdatavalid raises a sticky error
        force_rdv = 1;
        drive_inputs();
        step();
        force_rdv = 0;
        drive_inputs();
        repeat (3) step();
        chk("spurious_rdv_err", 256'(last_err), 256'(1));
        do_reset();
        chk("err_cleared_by_reset", 256'(last_err), 256'(0));

        // Spurious writeack
        force_wack = 1;
        drive_inputs();
        step();
        force_wack = 0;
        drive_inputs();
        repeat (2) step();
        chk("spurious_wack_err", 256'(last_err), 256'(1));
        do_reset();

        // burstcount 0 read counts as one beat and flags error
        issue(0, 0, 0);
        drive_inputs();
        wait_idle(30);
        step();
        chk("bc0_err", 256'(last_err), 256'(1));
        do_reset();

        // Read by the locked master mid-burst
        issue(1, 1, 3);
        drive_inputs();
        step();
        a_viol[1] = 1;
        drive_inputs();
        step();
        step();
        wait_idle(30);
        chk("lock_read_err", 256'(last_err), 256'(1));
        do_reset();

        // Reset during beat 2 of a 4-beat write
        issue(0, 1, 4);
        drive_inputs();
        step();
        reset = 1;
        drive_inputs();
        step();
        reset = 0;
        drive_inputs();
        step();
        chk("rst_mid_avm_write", 256'(last_avm_write), 256'(0));
        chk("rst_mid_err", 256'(last_err), 256'(0));
        force_wack = 1;
        drive_inputs();
        step();
        force_wack = 0;
        drive_inputs();
        step();
        chk("inflight_after_rst_err", 256'(last_err), 256'(1));
        do_reset();

        // Random traffic
        p_wait = 20; p_rdv = 60; p_wack = 40; p_new = 40;
        repeat (1500) step();
        p_new = 0; p_wait = 0; p_rdv = 100; p_wack = 100;
        wait_idle(300);
        chk("random_err", 256'(last_err), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
